// File: rtl/sipo8_rx_pkg.sv
// Shared types and constants for the sipo8_rx serial byte assembler.
package sipo8_rx_pkg;
  localparam int         DATA_W   = 8;
  localparam logic [3:0] BIT_TERM = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHIFT  = 2'b01,
    PARITY = 2'b10,
    DONE   = 2'b11
  } state_e;

  // Nonzero when the data bits and the received parity bit disagree.
  function automatic logic par_err_f(logic [DATA_W-1:0] d, logic p, logic odd);
    return (^d) ^ p ^ odd;
  endfunction
endpackage

// File: rtl/sipo8_rx_if.sv
// Serial input / parallel output bundle of sipo8_rx.
interface sipo8_rx_if;
  logic       start;
  logic       bit_in;
  logic       bit_vld;
  logic [7:0] byte_out;
  logic       load;
  logic       par_err;
  logic       busy;

  modport master (output start, bit_in, bit_vld,
                  input  byte_out, load, par_err, busy);
  modport slave  (input  start, bit_in, bit_vld,
                  output byte_out, load, par_err, busy);
endinterface

// File: rtl/sipo8_rx_shift8_sipo.sv
// 8-bit serial-in shift register with clear and selectable shift direction.
module shift8_sipo
  import sipo8_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              msb_first,
  input  logic              bit_in,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] nxt
);
  logic [DATA_W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clr)
      sr_d = '0;
    else if (shift_en)
      sr_d = msb_first ? {sr_q[DATA_W-2:0], bit_in} : {bit_in, sr_q[DATA_W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;

  // nxt lets the parent capture the completed byte on the edge that shifts in the last bit.
  assign q   = sr_q;
  assign nxt = sr_d;
endmodule

// File: rtl/sipo8_rx.sv
// Serial-to-byte assembler: frame FSM, bit counter, optional parity check,
// one-cycle load strobe for the downstream holding register.
module sipo8_rx
  import sipo8_rx_pkg::*;
#(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic         Clk,
  input  logic         Res,
  sipo8_rx_if.slave    bus
);
  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic              perr_q, perr_d;
  logic              load_q, load_d;
  logic              busy_q, busy_d;
  logic              sh_clr, sh_en;
  logic [DATA_W-1:0] sh_q, sh_nxt;
  logic              last_data;

  assign last_data = (cnt_q == 4'(BIT_TERM - 4'd1));

  shift8_sipo u_sr (
    .clk      (Clk),
    .rst_n    (Res),
    .clr      (sh_clr),
    .shift_en (sh_en),
    .msb_first(MSB_FIRST),
    .bit_in   (bus.bit_in),
    .q        (sh_q),
    .nxt      (sh_nxt)
  );

  always_ff @(posedge Clk or negedge Res)
    if (!Res) state_q <= IDLE;
    else      state_q <= state_d;

  // start wins over everything, including a bit offered in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.start) state_d = SHIFT;
      SHIFT:  if (bus.start) state_d = SHIFT;
              else if (bus.bit_vld && last_data) state_d = PARITY_EN ? PARITY : DONE;
      PARITY: if (bus.start) state_d = SHIFT;
              else if (bus.bit_vld) state_d = DONE;
      DONE:   state_d = bus.start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    byte_d = byte_q;
    perr_d = perr_q;
    sh_clr = 1'b0;
    sh_en  = 1'b0;
    if (bus.start) begin
      sh_clr = 1'b1;
      cnt_d  = '0;
    end else begin
      case (state_q)
        SHIFT: if (bus.bit_vld) begin
          sh_en = 1'b1;
          cnt_d = 4'(cnt_q + 4'd1);
          if (last_data && !PARITY_EN) begin
            byte_d = sh_nxt;
            perr_d = 1'b0;
          end
        end
        PARITY: if (bus.bit_vld) begin
          byte_d = sh_q;
          perr_d = par_err_f(sh_q, bus.bit_in, PARITY_ODD);
        end
        DONE:    cnt_d = '0;
        default: ;
      endcase
    end
    load_d = (state_d == DONE);
    busy_d = (state_d == SHIFT) || (state_d == PARITY);
  end

  always_ff @(posedge Clk or negedge Res)
    if (!Res) begin
      cnt_q  <= '0;
      byte_q <= '0;
      perr_q <= 1'b0;
      load_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      byte_q <= byte_d;
      perr_q <= perr_d;
      load_q <= load_d;
      busy_q <= busy_d;
    end

  assign bus.byte_out = byte_q;
  assign bus.load     = load_q;
  assign bus.par_err  = perr_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sipo8_rx.sv
// Scoreboard bench for sipo8_rx: four parameter variants share one serial stream,
// each checked against a frame-level model built from bit queues.
module tb_sipo8_rx;
  logic Clk = 1'b0, Res = 1'b0;
  logic start = 1'b0, bit_in = 1'b0, bit_vld = 1'b0;
  logic done_flag = 1'b0;
  int   n_chk = 0, n_pass = 0;

  localparam logic [3:0] PE_V  = 4'b1001;
  localparam logic [3:0] ODD_V = 4'b1000;
  localparam logic [3:0] MSB_V = 4'b0011;

  logic [3:0] busy_w, load_w, perr_w;
  logic [7:0] byte_w [4];

  always #5 Clk = ~Clk;

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d: got %0h expected %0h", name, k, act, exp);
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g
    localparam bit PE  = PE_V[k];
    localparam bit ODD = ODD_V[k];
    localparam bit MSB = MSB_V[k];

    sipo8_rx_if ifc ();
    assign ifc.start   = start;
    assign ifc.bit_in  = bit_in;
    assign ifc.bit_vld = bit_vld;

    sipo8_rx #(.PARITY_EN(PE), .PARITY_ODD(ODD), .MSB_FIRST(MSB)) dut (
      .Clk(Clk), .Res(Res), .bus(ifc)
    );

    assign busy_w[k] = ifc.busy;
    assign load_w[k] = ifc.load;
    assign perr_w[k] = ifc.par_err;
    assign byte_w[k] = ifc.byte_out;

    logic [8:0] sb[$];
    logic       m_active, m_load;

    // Reference: collect accepted bits of a frame, pack and score when complete.
    initial begin
      bit         q[$];
      logic [7:0] b;
      logic       p;
      m_active = 1'b0;
      m_load   = 1'b0;
      forever begin
        @(posedge Clk or negedge Res);
        if (!Res) begin
          m_active = 1'b0;
          m_load   = 1'b0;
          q.delete();
          sb.delete();
        end else begin
          m_load = 1'b0;
          if (start) begin
            m_active = 1'b1;
            q.delete();
          end else if (m_active && bit_vld) begin
            q.push_back(bit_in);
            if (q.size() == (PE ? 9 : 8)) begin
              b = '0;
              for (int i = 0; i < 8; i++)
                if (MSB) b[7-i] = q[i]; else b[i] = q[i];
              p = PE ? ((^b) ^ q[8] ^ ODD) : 1'b0;
              sb.push_back({p, b});
              m_active = 1'b0;
              m_load   = 1'b1;
            end
          end
        end
      end
    end

    initial begin
      logic [8:0] held, exp;
      held = '0;
      forever begin
        @(negedge Clk);
        if (!Res) held = '0;
        else begin
          chk("busy", k, 32'(ifc.busy), 32'(m_active));
          chk("load", k, 32'(ifc.load), 32'(m_load));
          if (ifc.load === 1'b1) begin
            if (sb.size() == 0) begin
              n_chk++;
              $display("FAIL load_without_frame inst%0d: got load=1 expected no load", k);
            end else begin
              exp  = sb.pop_front();
              held = exp;
              chk("byte_out", k, 32'(ifc.byte_out), 32'(exp[7:0]));
              chk("par_err", k, 32'(ifc.par_err), 32'(exp[8]));
            end
          end else begin
            chk("byte_hold", k, 32'(ifc.byte_out), 32'(held[7:0]));
            chk("perr_hold", k, 32'(ifc.par_err), 32'(held[8]));
          end
        end
      end
    end

    initial begin
      wait (done_flag);
      chk("sb_drained", k, 32'(sb.size()), 32'd0);
    end
  end

  task automatic drive(input logic st, input logic vld, input logic b);
    start = st; bit_vld = vld; bit_in = b;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 1'b0);
  endtask

  // seq[n-1] goes out first; gap idle cycles separate consecutive bits.
  task automatic send(input logic [8:0] seq, input int n, input int gap, input bit do_start);
    if (do_start) drive(1'b1, 1'($urandom), 1'($urandom));
    for (int i = n - 1; i >= 0; i--) begin
      drive(1'b0, 1'b1, seq[i]);
      if (i > 0) repeat (gap) drive(1'b0, 1'b0, 1'($urandom));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_byte"}, k, 32'(byte_w[k]), 32'd0);
      chk({tag, "_load"}, k, 32'(load_w[k]), 32'd0);
      chk({tag, "_busy"}, k, 32'(busy_w[k]), 32'd0);
      chk({tag, "_perr"}, k, 32'(perr_w[k]), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rp;
    #3;
    check_reset_outputs("rst");
    #9 Res = 1'b1;
    @(posedge Clk); #1;

    // reset in the middle of a frame, then stray bits that must not complete it
    send({8'hF0, 1'b0}, 9, 0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    repeat (4) drive(1'b0, 1'b1, 1'b1);
    #2 Res = 1'b0;
    #1 check_reset_outputs("midrst");
    #2 Res = 1'b1;
    @(posedge Clk); #1;
    repeat (8) drive(1'b0, 1'b1, 1'b1);
    idle(2);

    send({8'hC0, 1'b0}, 9, 0, 1'b1); idle(2);
    send({8'hA5, 1'b0}, 9, 0, 1'b1); idle(2);
    send({8'hA5, 1'b1}, 9, 0, 1'b1); idle(2);
    send({8'h3C, 1'b0}, 9, 3, 1'b1); idle(2);

    drive(1'b1, 1'b0, 1'b0);
    repeat (5) drive(1'b0, 1'b1, 1'($urandom));
    drive(1'b1, 1'b1, 1'b1);
    send({8'h5A, 1'b0}, 9, 0, 1'b0); idle(2);

    send({8'h81, 1'b0}, 9, 0, 1'b1);
    send({8'h7E, 1'b0}, 9, 0, 1'b1); idle(3);

    for (int it = 0; it < 60; it++) begin
      rb = 8'($urandom);
      rp = 1'($urandom);
      if ($urandom_range(0, 5) == 0)
        send({rb, rp}, $urandom_range(1, 8), 0, 1'b1);
      send({rb, rp}, 9, $urandom_range(0, 2), 1'b1);
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), 1'($urandom));
    end

    idle(4);
    done_flag = 1'b1;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sipo8_rx.md
Name: sipo8_rx

Overview:
- Serial-in, parallel-out byte assembler with a frame state machine and optional parity check.
- Collects 8 serial bits qualified by bit_vld and presents the assembled byte on byte_out.
- Issues a one-cycle load strobe that drives the enable of the downstream 8-bit holding register, whose data input is byte_out.
- Sits directly upstream of that register in the datapath.

Parameters:
- PARITY_EN, 1: 1 = a parity bit follows the 8 data bits and is checked; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Ignored when PARITY_EN=0.
- MSB_FIRST, 1: 1 = first received bit lands in byte_out[7]; 0 = first bit lands in byte_out[0].

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Res  input  1  reset, asynchronous, active-low. Res=0 resets immediately, independent of Clk.
- start  input  1  frame start request (one-cycle pulse).
- bit_in  input  1  serial data bit.
- bit_vld  input  1  bit_in is valid this cycle.
- byte_out  output  8  last completed byte; held between loads.
- load  output  1  one-cycle strobe; byte_out is new this cycle.
- par_err  output  1  parity result of the last completed frame.
- busy  output  1  a frame is in progress (SHIFT or PARITY state).

Behaviour:
- Reset (Res=0, async): state=IDLE, shift register=0, bit count=0, byte_out=8'h00, load=0, par_err=0, busy=0. Reset mid-frame discards the partial frame; no load is issued.
- All outputs are registered.
- States: IDLE, SHIFT, PARITY, DONE.
- IDLE:
  - start=1 -> SHIFT with count=0.
  - bit_vld is ignored in IDLE, including in the same cycle as start.
- SHIFT:
  - Each cycle with bit_vld=1 accepts bit_in into the shift register and increments count.
  - Cycles with bit_vld=0 hold all state; gaps of any length are legal.
  - MSB_FIRST=1: shift left, new bit enters at bit0. MSB_FIRST=0: shift right, new bit enters at bit7.
  - On acceptance of the 8th bit: go to PARITY if PARITY_EN=1, else go to DONE.
- PARITY:
  - The next bit_vld=1 cycle samples the parity bit p.
  - Error condition: (^data) ^ p ^ PARITY_ODD != 0.
  - Then go to DONE.
- DONE (exactly one cycle):
  - load=1; byte_out = assembled byte; par_err = computed error, held until the next load.
  - With PARITY_EN=0, par_err stays 0.
  - Next state is IDLE, or SHIFT if start=1 in the DONE cycle. This allows back-to-back frames with no idle cycle.
- Latency: load asserts in the cycle after the clock edge that accepts the last bit (8th data bit or parity bit).
- busy=1 exactly while state is SHIFT or PARITY; 0 in IDLE and DONE.
- start during SHIFT or PARITY:
  - Aborts the current frame; count=0; stays in SHIFT; no load.
  - start has priority over a simultaneous bit_vld, and that bit is dropped.
- byte_out and par_err never change except in the load cycle (or on reset).
- Count is 4 bits, saturating use only (0..8); no wrap is possible because the state changes at 8.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, SHIFT=2'b01, PARITY=2'b10, DONE=2'b11;
  - DATA_W=8;
  - the bit-count terminal value 8.
- One sub-module: shift8_sipo, an 8-bit shift register with shift-enable, clear and direction inputs, and async active-low reset. The FSM, counter and parity check stay in sipo8_rx.

Test Plan:
1. Reset mid-frame: start, 4 bits, then Res=0 between clock edges -> byte_out=00, load=0, busy=0 immediately. After release, no load for the aborted frame.
2. PARITY_EN=0, MSB_FIRST=1: start, bits 1,1,0,0,0,0,0,0 on consecutive cycles -> load=1 for one cycle the cycle after the 8th bit, byte_out=8'hC0. Same stimulus with MSB_FIRST=0 -> 8'h03.
3. PARITY_EN=1, even parity: bits of 8'hA5 then parity 0 -> byte_out=A5, par_err=0. Repeat with parity 1 -> byte_out=A5, par_err=1.
4. Gapped input: bits of 8'h3C with bit_vld low for 3 cycles between each bit -> busy stays 1 throughout; a single load with byte_out=3C; byte_out unchanged until then.
5. Abort: start, 5 bits, start again with bit_vld=1 in the same cycle, then 8 bits of 8'h5A -> exactly one load, byte_out=5A.
6. Back-to-back: start asserted in the DONE cycle of frame 8'h81, then frame 8'h7E -> two loads separated by exactly 8 (or 9 with parity) bit cycles, values 81 then 7E, busy never drops between frames except in the DONE cycle.
